mips_data_mem_responder: RTL and testbench

- Memory-side responder for the MIPS core's load/store port; the processor initiates, this block answers.
- Accepts one byte, half-word or word request per valid/ready handshake.
- Holds a word-addressed storage array behind a programmable number of wait states.
- Returns read data or a write acknowledge through a valid/ready response channel.
- Sits between the pipelined core's MEM stage and its stall logic: a load or store stays stalled until its response is taken.

---
 rtl/mips_data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mips_data_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the MIPS load/store port: one byte/half/word request per
// handshake, answered after WAIT_CYCLES wait states through a valid/ready response channel.
module mips_data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [3:0]        cnt_r;
   logic              lat_write_r;
   logic [31:0]       lat_addr_r;
   logic [31:0]       lat_wdata_r;
   logic [1:0]        lat_size_r;
   logic              lat_signed_r;
   logic [31:0]       mem_r [DEPTH_WORDS];
   logic [31:0]       resp_rdata_r;
   logic              resp_error_r;
   logic              req_ready_s;
   logic              resp_valid_s;
   logic              access_s;
   logic              err_s;
   logic [AW-1:0]     widx_s;

   // Merge right-justified store data into the addressed lanes of a word.
   function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
      logic [31:0] r;
      r = old_word;
      case (size)
         2'd0:    r[{off, 3'b000} +: 8]        = wdata[7:0];
         2'd1:    r[{off[1], 4'b0000} +: 16]   = wdata[15:0];
         2'd2:    r                            = wdata;
         default: r                            = old_word;
      endcase
      return r;
   endfunction

   // Right-justify the addressed byte/half and sign- or zero-extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'd0:    r = {{24{sgn & b[7]}}, b};
         2'd1:    r = {{16{sgn & h[15]}}, h};
         2'd2:    r = word;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   assign widx_s   = lat_addr_r[AW+1:2];
   // The edge leaving WAIT with an expired counter is the single memory-access edge.
   assign access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
   assign err_s    = (lat_size_r == 2'b11)
                   || ((lat_size_r == 2'b01) && lat_addr_r[0])
                   || ((lat_size_r == 2'b10) && (lat_addr_r[1:0] != 2'b00))
                   || ((lat_addr_r >> (AW + 2)) != 32'd0);

   // State register, wait counter and request latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 4'd0;
         lat_write_r  <= 1'b0;
         lat_addr_r   <= 32'd0;
         lat_wdata_r  <= 32'd0;
         lat_size_r   <= 2'd0;
         lat_signed_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if ((state_r == ST_IDLE) && req_valid) begin
            cnt_r        <= 4'(WAIT_CYCLES);
            lat_write_r  <= req_write;
            lat_addr_r   <= req_addr;
            lat_wdata_r  <= req_wdata;
            lat_size_r   <= req_size;
            lat_signed_r <= req_signed;
         end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
         end
      end
   end

   // Next-state logic; every request passes through WAIT so that latency is WAIT_CYCLES+1.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: if (req_valid)          state_s = ST_WAIT; else state_s = ST_IDLE;
         ST_WAIT: if (cnt_r == 4'd0)      state_s = ST_RESP; else state_s = ST_WAIT;
         ST_RESP: if (resp_ready)         state_s = ST_IDLE; else state_s = ST_RESP;
         default:                         state_s = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      req_ready_s  = 1'b0;
      resp_valid_s = 1'b0;
      case (state_r)
         ST_IDLE: req_ready_s  = 1'b1;
         ST_WAIT: req_ready_s  = 1'b0;
         ST_RESP: resp_valid_s = 1'b1;
         default: req_ready_s  = 1'b0;
      endcase
   end

   // Storage is deliberately not reset; stores commit only on the access edge.
   always_ff @(posedge clk) begin
      if (access_s && lat_write_r && !err_s) begin
         mem_r[widx_s] <= store_merge(mem_r[widx_s], lat_wdata_r, lat_size_r, lat_addr_r[1:0]);
      end
   end

   // Response payload, captured on the access edge and held until the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_rdata_r <= 32'd0;
         resp_error_r <= 1'b0;
      end else if (access_s) begin
         resp_error_r <= err_s;
         resp_rdata_r <= (err_s || lat_write_r) ? 32'd0
                       : load_extract(mem_r[widx_s], lat_size_r, lat_addr_r[1:0], lat_signed_r);
      end else if ((state_r == ST_RESP) && resp_ready) begin
         resp_rdata_r <= 32'd0;
         resp_error_r <= 1'b0;
      end
   end

   assign req_ready  = req_ready_s;
   assign resp_valid = resp_valid_s;
   assign resp_rdata = resp_rdata_r;
   assign resp_error = resp_error_r;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Self-checking bench: a byte-array reference model drives expectations for a
// WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance sharing the request bus.
module tb_mips_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;

   logic        req_valid = 1'b0,  resp_ready = 1'b0;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_rdata;

   logic        req_valid0 = 1'b0, resp_ready0 = 1'b0;
   logic        req_ready0, resp_valid0, resp_error0;
   logic [31:0] resp_rdata0;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_bytes [2][1024];

   always #5 clk = ~clk;

   mips_data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .req_signed(req_signed), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error));

   mips_data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .req_signed(req_signed), .resp_valid(resp_valid0),
      .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_error(resp_error0));

   // Reference: byte-addressed little-endian memory of 1024 bytes.
   function automatic void model(input int d, input bit w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                                 output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] v;
      er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
           || (a >= 32'd1024);
      rd = 32'd0;
      if (er) return;
      n = 1 << sz;
      if (w) begin
         for (int i = 0; i < n; i++) ref_bytes[d][a + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[d][a + i]) << (8 * i));
         if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
         rd = v;
      end
   endfunction

   // Runs one transaction on instance d (0 = WAIT 2, 1 = WAIT 0); lat = edges after accept, -1 on timeout.
   task automatic do_txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit sg,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic [31:0] exp_rd, output logic exp_er);
      model(d, w, a, wd, sz, sg, exp_rd, exp_er);
      req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
      if (d == 1) req_valid0 = 1'b1; else req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_valid0 = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_write = 1'($urandom);
      lat = -1; rd = 32'hx; er = 1'bx;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (((d == 1) ? resp_valid0 : resp_valid) === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat > 0) begin
         rd = (d == 1) ? resp_rdata0 : resp_rdata;
         er = (d == 1) ? resp_error0 : resp_error;
         if (d == 1) resp_ready0 = 1'b1; else resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0; resp_ready0 = 1'b0;
      end
   endtask

   task automatic test_reset();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
      checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", resp_error); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      logic [31:0] rd, erd; logic er, eer; int lat;
      do_txn(0, 1'b1, 32'h10, 32'h12345678, 2'd2, 1'b0, rd, er, lat, erd, eer);
      checks++; if (lat !== 3 || er !== eer || rd !== erd) begin errors++;
         $display("FAIL sw_0x10 lat %0d rd %h er %b want lat 3 rd %h er %b", lat, rd, er, erd, eer); end
      do_txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er, lat, erd, eer);
      checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
      checks++; if (rd !== erd || er !== eer) begin errors++;
         $display("FAIL lw_0x10 rd %h er %b want rd %h er %b", rd, er, erd, eer); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_after_handshake req_ready %b want 1", req_ready); end
   endtask

   task automatic test_lanes();
      logic [31:0] rd, erd; logic er, eer; int lat;
      do_txn(0, 1'b1, 32'h13, 32'h55AA, 2'd0, 1'b0, rd, er, lat, erd, eer);
      checks++; if (lat !== 3 || er !== eer || rd !== erd) begin errors++;
         $display("FAIL sb_0x13 lat %0d rd %h er %b want rd %h er %b", lat, rd, er, erd, eer); end
      do_txn(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd, er, lat, erd, eer);
      checks++; if (rd !== erd || er !== eer) begin errors++;
         $display("FAIL lh_0x12 rd %h er %b want rd %h er %b", rd, er, erd, eer); end
      do_txn(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, rd, er, lat, erd, eer);
      checks++; if (rd !== erd || er !== eer) begin errors++;
         $display("FAIL lhu_0x12 rd %h er %b want rd %h er %b", rd, er, erd, eer); end
      do_txn(0, 1'b0, 32'h10, 32'h0, 2'd0, 1'b1, rd, er, lat, erd, eer);
      checks++; if (rd !== erd || er !== eer) begin errors++;
         $display("FAIL lb_0x10 rd %h er %b want rd %h er %b", rd, er, erd, eer); end
   endtask

   task automatic test_errors();
      logic [31:0] rd, erd; logic er, eer; int lat;
      logic [31:0] addrs [5] = '{32'h11, 32'h13, 32'h10, 32'h400, 32'h10};
      logic [1:0]  sizes [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
      bit          wrs   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         do_txn(0, wrs[i], addrs[i], 32'hCAFEF00D, sizes[i], 1'b1, rd, er, lat, erd, eer);
         checks++; if (lat !== 3 || rd !== erd || er !== eer) begin errors++;
            $display("FAIL err_case%0d lat %0d rd %h er %b want lat 3 rd %h er %b", i, lat, rd, er, erd, eer); end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, wd; logic er, eer; int lat; logic [1:0] sz; bit w, sg;
      for (int i = 0; i < 16; i++)
         do_txn(0, 1'b1, 32'h40 + 32'(4 * i), $urandom, 2'd2, 1'b0, rd, er, lat, erd, eer);
      for (int i = 0; i < 60; i++) begin
         a  = 32'h40 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = a | (32'h400 << $urandom_range(0, 21));
         sz = 2'($urandom_range(0, 3));
         w  = 1'($urandom); sg = 1'($urandom); wd = $urandom;
         do_txn(0, w, a, wd, sz, sg, rd, er, lat, erd, eer);
         checks++; if (lat !== 3 || rd !== erd || er !== eer) begin errors++;
            $display("FAIL rand%0d w%b a %h sz %0d sg %b: lat %0d rd %h er %b want lat 3 rd %h er %b",
                     i, w, a, sz, sg, lat, rd, er, erd, eer); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, erd, held; logic er, eer; int lat; logic dummy_er;
      model(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, erd, dummy_er);
      req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_signed = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) begin lat = i; break; end
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", lat); end
      held = resp_rdata;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_size = 2'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (resp_valid !== 1'b1 || resp_rdata !== erd || resp_rdata !== held || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d valid %b rdata %h ready %b want valid 1 rdata %h ready 0",
                               i, resp_valid, resp_rdata, req_ready, erd); end
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
         $display("FAIL bp_release valid %b ready %b want valid 0 ready 1", resp_valid, req_ready); end
      do_txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er, lat, erd, eer);
      checks++; if (rd !== erd || er !== eer) begin errors++;
         $display("FAIL bp_store_ignored rd %h er %b want rd %h er %b", rd, er, erd, eer); end
   endtask

   task automatic test_wait0();
      logic [31:0] rd, erd; logic er, eer; int lat;
      do_txn(1, 1'b1, 32'h30, 32'hA5C3_1E0F, 2'd2, 1'b0, rd, er, lat, erd, eer);
      checks++; if (lat !== 1 || er !== eer) begin errors++; $display("FAIL w0_sw lat %0d er %b want lat 1 er %b", lat, er, eer); end
      for (int i = 0; i < 4; i++) begin
         do_txn(1, 1'b0, 32'h30 + 32'(i), 32'h0, 2'd0, 1'(i), rd, er, lat, erd, eer);
         checks++; if (lat !== 1 || rd !== erd || er !== eer) begin errors++;
            $display("FAIL w0_lb%0d lat %0d rd %h er %b want lat 1 rd %h er %b", i, lat, rd, er, erd, eer); end
      end
   endtask

   task automatic test_reset_mid_store();
      logic [31:0] rd, erd; logic er, eer; int lat;
      do_txn(0, 1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, rd, er, lat, erd, eer);
      req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; req_size = 2'd2; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
         $display("FAIL mid_reset valid %b ready %b want valid 0 ready 1", resp_valid, req_ready); end
      repeat (4) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      do_txn(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er, lat, erd, eer);
      checks++; if (lat !== 3 || rd !== erd || er !== eer) begin errors++;
         $display("FAIL mid_reset_keep lat %0d rd %h er %b want rd %h er %b", lat, rd, er, erd, eer); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_word();
      test_lanes();
      test_errors();
      test_random();
      test_backpressure();
      test_wait0();
      test_reset_mid_store();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
